// File: rtl/recv_arbiter.sv
// recv_arbiter: round-robin sharing of one frame receiver among NUM_REQ byte-stream sources.
module recv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 2048,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rx_start,
  output logic [7:0]           rx_data,
  output logic                 rx_abort,
  input  logic                 rx_ready,
  input  logic                 rx_vld,
  input  logic [7:0]           rx_out,
  output logic                 done,
  output logic [ID_W-1:0]      done_id,
  output logic [1:0]           done_status,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, START, ACTIVE, ABORT, REPORT} state_t;
  state_t state, nxt;
  logic [ID_W-1:0] winner, ptr, pick;
  logic found;
  logic [15:0] cnt;
  logic last_vld;
  logic [7:0] last_out;
  logic [1:0] frame_status;
  // first requester after the pointer, wrapping so the pointer itself is searched last
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end
  always_comb frame_status = !last_vld ? 2'd2 : (last_out == 8'h00) ? 2'd0 : 2'd1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (en && rx_ready && found) ? START : IDLE;
      START:   nxt = ACTIVE;
      ACTIVE:  nxt = rx_ready ? REPORT : (cnt == 16'(TIMEOUT - 1)) ? ABORT : ACTIVE;
      ABORT:   nxt = REPORT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      winner      <= '0;
      ptr         <= ID_W'(NUM_REQ - 1);
      cnt         <= '0;
      last_vld    <= 1'b0;
      last_out    <= '0;
      done_id     <= '0;
      done_status <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == START) winner <= pick;
      if (state == START) begin
        ptr      <= winner;
        cnt      <= '0;
        last_vld <= 1'b0;
        last_out <= '0;
      end
      if (state == ACTIVE) begin
        cnt      <= cnt + 16'd1;
        last_vld <= rx_vld;
        last_out <= rx_out;
      end
      if (nxt == REPORT) begin
        done_id     <= winner;
        done_status <= (state == ABORT) ? 2'd3 : frame_status;
      end
    end
  end
  assign gnt      = (state == START || state == ACTIVE) ? NUM_REQ'(1) << winner : '0;
  assign rx_data  = (gnt != '0) ? req_data[8*winner +: 8] : 8'h00;
  assign rx_start = state == START;
  assign rx_abort = state == ABORT;
  assign done     = state == REPORT;
  assign busy     = state != IDLE;
endmodule

// File: tb/tb_recv_arbiter.sv
// tb_recv_arbiter: randomized frames against a round-robin/outcome reference model.
module tb_recv_arbiter;
  localparam int N = 4, TO = 64;
  logic clk = 0, rst = 0, en = 0, rx_ready = 1, rx_vld = 0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] rx_out = '0;
  logic [N-1:0] gnt;
  logic rx_start, rx_abort, done, busy;
  logic [7:0] rx_data;
  logic [1:0] done_id, done_status;
  int checks = 0, failures = 0;
  int ptr = N - 1;

  recv_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data), .gnt(gnt),
    .rx_start(rx_start), .rx_data(rx_data), .rx_abort(rx_abort), .rx_ready(rx_ready),
    .rx_vld(rx_vld), .rx_out(rx_out), .done(done), .done_id(done_id),
    .done_status(done_status), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
  endtask

  // kind: 0 ok, 1 error, 2 filtered, 3 timeout; len = ACTIVE cycles before rx_ready
  task automatic run_frame(input logic [N-1:0] r, input int kind, input int len, input int gap, input bit en_only);
    int w, m;
    logic [7:0] fin;
    step();
    req = r;
    for (int g = 0; g < gap; g++) begin
      m = en_only ? 0 : $urandom_range(2);
      en = (m == 1);
      rx_ready = (m != 2) && (m != 1);
      @(negedge clk);
      chk("blocked_gnt", gnt, 0);
      chk("blocked_busy", busy, 0);
      step();
    end
    en = 1;
    rx_ready = 1;
    w = rr_pick(r);
    @(negedge clk);
    chk("idle_gnt", gnt, 0);
    chk("idle_busy", busy, 0);
    step();
    @(negedge clk);
    chk("start_gnt", gnt, 1 << w);
    chk("start_pulse", rx_start, 1);
    chk("start_data", rx_data, req_data[8*w +: 8]);
    ptr = w;
    fin = (kind == 0) ? 8'h00 : {4'hF, 4'($urandom)};
    for (int k = 0; (kind == 3) ? k < TO : k <= len; k++) begin
      step();
      if ($urandom_range(3) == 0) req = N'($urandom);
      rx_ready = (kind != 3) && (k == len);
      rx_out = 8'($urandom);
      rx_vld = 1'($urandom);
      if (kind != 3 && k == len - 1) begin
        rx_vld = (kind < 2);
        rx_out = fin;
      end
      if (rx_ready) rx_vld = 0;
      @(negedge clk);
      chk("act_gnt", gnt, 1 << w);
      chk("act_start", rx_start, 0);
      chk("act_abort", rx_abort, 0);
      chk("act_done", done, 0);
      chk("act_data", rx_data, req_data[8*w +: 8]);
    end
    if (kind == 3) begin
      step();
      rx_vld = 0;
      @(negedge clk);
      chk("abort_pulse", rx_abort, 1);
      chk("abort_gnt", gnt, 0);
      chk("abort_done", done, 0);
    end
    step();
    rx_ready = 1;
    rx_vld = 0;
    @(negedge clk);
    chk("rep_done", done, 1);
    chk("rep_id", done_id, w);
    chk("rep_status", done_status, kind);
    chk("rep_gnt", gnt, 0);
    chk("rep_data", rx_data, 0);
    step();
    req = '0;
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_id_hold", done_id, w);
    chk("post_status_hold", done_status, kind);
  endtask

  initial begin
    int kind;
    logic [N-1:0] r;
    #2 rst = 1;
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", rx_start, 0);
    chk("rst_abort", rx_abort, 0);
    chk("rst_done", done, 0);
    chk("rst_id", done_id, 0);
    chk("rst_status", done_status, 0);
    chk("rst_data", rx_data, 0);
    @(posedge clk);
    #1 rst = 0;
    run_frame(4'b0001, 0, 8, 0, 0);
    repeat (5) run_frame(4'b1111, 0, $urandom_range(1, 12), 0, 0);
    run_frame(4'b0100, 1, 10, 0, 0);
    run_frame(4'b0010, 2, 3, 0, 0);
    run_frame(4'b1000, 3, TO + 10, 0, 0);
    run_frame(4'b0001, 0, 1, 0, 0);
    run_frame(4'b0001, 0, TO - 1, 0, 0);
    run_frame(4'b1111, 0, 4, 20, 1);
    // asynchronous reset in the middle of a frame
    step();
    en = 1;
    req = 4'b0001;
    rx_ready = 1;
    step();
    rx_ready = 0;
    step();
    step();
    @(negedge clk);
    chk("pre_rst_gnt", gnt, 1);
    #2 rst = 1;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_start", rx_start, 0);
    chk("async_done", done, 0);
    chk("async_busy", busy, 0);
    @(posedge clk);
    #1 rst = 0;
    ptr = N - 1;
    rx_ready = 1;
    req = '0;
    run_frame(4'b0010, 0, 5, 0, 0);
    repeat (30) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      kind = ($urandom_range(7) == 0) ? 3 : $urandom_range(2);
      run_frame(r, kind, (kind == 3) ? TO + 10 : $urandom_range(1, TO - 1), $urandom_range(3), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
